register_file: RTL and testbench

- 16 x 32-bit ARM-style general register file at the ID/WB boundary.
- Three combinational read ports feed the ID stage: Pa (Rn), Pb (Rm), and Pd (Rd, the store-data source).
- A write-back port is driven by WB_RF_enable and the write-back result. A link port is driven by BL.
- R15 reads return the program counter. A WB write to R15 becomes a registered PC-redirect request.

---
 rtl/register_file_if.sv | 34 +++
 rtl/register_file.sv | 73 +++++++
 tb/tb_register_file.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - ID/WB-side bus bundle for the register file
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
);
  logic [3:0]        ra_addr;
  logic [3:0]        rb_addr;
  logic [3:0]        rd_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] rd_data;
  logic [PC_W-1:0]   pc_in;
  logic              wb_we;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              lk_we;
  logic [PC_W-1:0]   lk_data;
  logic              pc_wr_req;
  logic [PC_W-1:0]   pc_wr_target;

  // Pipeline side: issues addresses, write-back and link traffic.
  modport master (
    output ra_addr, rb_addr, rd_addr, pc_in,
    output wb_we, wb_addr, wb_data, lk_we, lk_data,
    input  ra_data, rb_data, rd_data, pc_wr_req, pc_wr_target
  );

  // Register file side.
  modport slave (
    input  ra_addr, rb_addr, rd_addr, pc_in,
    input  wb_we, wb_addr, wb_data, lk_we, lk_data,
    output ra_data, rb_data, rd_data, pc_wr_req, pc_wr_target
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 16x32 ARM-style register file with write-before-read bypass and R15 redirect
module register_file #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 8,
  parameter int LINK_REG = 14
) (
  input logic            clk,
  input logic            R,
  register_file_if.slave bus
);

  // R0..R14 only; R15 is the PC and has no storage here.
  logic [DATA_W-1:0] regs_q [0:14];
  logic [DATA_W-1:0] regs_d [0:14];
  logic [DATA_W-1:0] vis    [0:15];
  logic              pc_req_q, pc_req_d;
  logic [PC_W-1:0]   pc_tgt_q, pc_tgt_d;
  logic [DATA_W-1:0] lk_ext;
  logic [DATA_W-1:0] pc_ext;

  assign lk_ext = {{(DATA_W-PC_W){1'b0}}, bus.lk_data};
  assign pc_ext = {{(DATA_W-PC_W){1'b0}}, bus.pc_in};

  // Next register contents: WB first, link applied last so it wins on R14.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < 15; i++) begin
      if (bus.wb_we && bus.wb_addr == 4'(i)) begin
        regs_d[i] = bus.wb_data;
      end
    end
    if (bus.lk_we) begin
      regs_d[LINK_REG] = lk_ext;
    end
  end

  // Read view: the next-state value is exactly the bypassed value; forced to 0 while in reset.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      vis[i] = R ? regs_d[i] : '0;
    end
    vis[15] = pc_ext;
  end

  assign bus.ra_data = vis[bus.ra_addr];
  assign bus.rb_data = vis[bus.rb_addr];
  assign bus.rd_data = vis[bus.rd_addr];

  // Redirect request: one-cycle pulse per R15 write, target held between writes.
  always_comb begin
    pc_req_d = bus.wb_we && (bus.wb_addr == 4'd15);
    pc_tgt_d = pc_req_d ? bus.wb_data[PC_W-1:0] : pc_tgt_q;
  end

  // State update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
      pc_req_q <= 1'b0;
      pc_tgt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      pc_req_q <= pc_req_d;
      pc_tgt_q <= pc_tgt_d;
    end
  end

  assign bus.pc_wr_req    = pc_req_q;
  assign bus.pc_wr_target = pc_tgt_q;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard testbench for register_file
module tb_register_file;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  localparam int S_RA = 0, S_RB = 1, S_RD = 2, S_REQ = 3, S_TGT = 4;

  logic clk;
  logic R;
  exp_t sb[$];
  int   n_checks;
  int   n_pass;

  register_file_if #(.DATA_W(32), .PC_W(8)) bus ();

  register_file #(.DATA_W(32), .PC_W(8), .LINK_REG(14)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the DUT, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        S_RA:    act = bus.ra_data;
        S_RB:    act = bus.rb_data;
        S_RD:    act = bus.rd_data;
        S_REQ:   act = {31'd0, bus.pc_wr_req};
        default: act = {24'd0, bus.pc_wr_target};
      endcase
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    R = 1'b0;
    bus.ra_addr = 4'd0; bus.rb_addr = 4'd0; bus.rd_addr = 4'd0;
    bus.pc_in   = 8'h0C;
    bus.wb_we   = 1'b0; bus.wb_addr = 4'd0; bus.wb_data = 32'd0;
    bus.lk_we   = 1'b0; bus.lk_data = 8'd0;

    // Reset state
    cyc();
    bus.ra_addr = 4'd15; bus.rb_addr = 4'd0; bus.rd_addr = 4'd14;
    expect_val("rst_r15", S_RA, 32'h0000000C);
    expect_val("rst_r0",  S_RB, 32'h0);
    expect_val("rst_r14", S_RD, 32'h0);
    expect_val("rst_req", S_REQ, 32'h0);
    expect_val("rst_tgt", S_TGT, 32'h0);
    cyc();
    R = 1'b1;

    // Write R3, then read on all three ports
    cyc();
    bus.wb_we = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'hDEADBEEF;
    bus.ra_addr = 4'd3;
    expect_val("wr3_bypass", S_RA, 32'hDEADBEEF);
    cyc();
    bus.wb_we = 1'b0;
    bus.ra_addr = 4'd3; bus.rb_addr = 4'd3; bus.rd_addr = 4'd3;
    expect_val("rd3_a", S_RA, 32'hDEADBEEF);
    expect_val("rd3_b", S_RB, 32'hDEADBEEF);
    expect_val("rd3_d", S_RD, 32'hDEADBEEF);
    cyc();
    bus.ra_addr = 4'd4;
    expect_val("r4_zero", S_RA, 32'h0);

    // Same-cycle bypass on Pb
    bus.wb_we = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 32'h12345678;
    bus.rb_addr = 4'd5;
    expect_val("byp5_pre", S_RB, 32'h12345678);
    cyc();
    bus.wb_we = 1'b0;
    expect_val("byp5_post", S_RB, 32'h12345678);

    // Link vs WB on R14: link wins, also on the bypass path
    cyc();
    bus.lk_we = 1'b1; bus.lk_data = 8'h20;
    bus.wb_we = 1'b1; bus.wb_addr = 4'd14; bus.wb_data = 32'hFFFFFFFF;
    bus.ra_addr = 4'd14; bus.rd_addr = 4'd15;
    expect_val("lk_pre", S_RA, 32'h00000020);
    expect_val("r15_pc", S_RD, 32'h0000000C);
    cyc();
    bus.lk_we = 1'b0; bus.wb_we = 1'b0;
    expect_val("lk_post", S_RA, 32'h00000020);

    // R15 write: no read bypass, registered redirect
    cyc();
    bus.wb_we = 1'b1; bus.wb_addr = 4'd15; bus.wb_data = 32'h00000140;
    bus.ra_addr = 4'd15;
    expect_val("r15_nobyp", S_RA, 32'h0000000C);
    expect_val("req_pre",   S_REQ, 32'h0);
    cyc();
    bus.wb_we = 1'b0;
    bus.ra_addr = 4'd3; bus.rb_addr = 4'd14; bus.rd_addr = 4'd5;
    expect_val("req_pulse", S_REQ, 32'h1);
    expect_val("tgt_40",    S_TGT, 32'h40);
    expect_val("r3_keep",   S_RA, 32'hDEADBEEF);
    expect_val("r14_keep",  S_RB, 32'h00000020);
    expect_val("r5_keep",   S_RD, 32'h12345678);
    cyc();
    expect_val("req_drop",  S_REQ, 32'h0);
    expect_val("tgt_hold",  S_TGT, 32'h40);

    // Back-to-back R15 writes, reset during the second pulse
    bus.wb_we = 1'b1; bus.wb_addr = 4'd15; bus.wb_data = 32'h00000010;
    cyc();
    bus.wb_data = 32'h00000018;
    expect_val("b2b_req1", S_REQ, 32'h1);
    expect_val("b2b_tgt1", S_TGT, 32'h10);
    cyc();
    bus.wb_we = 1'b0;
    expect_val("b2b_req2", S_REQ, 32'h1);
    expect_val("b2b_tgt2", S_TGT, 32'h18);
    @(negedge clk);
    #1;
    R = 1'b0;
    bus.lk_we = 1'b1; bus.lk_data = 8'h77;
    bus.ra_addr = 4'd3; bus.rb_addr = 4'd14; bus.rd_addr = 4'd15;
    #1;
    expect_val("mid_rst_req", S_REQ, 32'h0);
    expect_val("mid_rst_tgt", S_TGT, 32'h0);
    expect_val("mid_rst_r3",  S_RA, 32'h0);
    expect_val("mid_rst_lk",  S_RB, 32'h0);
    expect_val("mid_rst_r15", S_RD, 32'h0000000C);

    // Writes are blocked while R is low
    bus.lk_we = 1'b0;
    bus.wb_we = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'hAAAA5555;
    cyc();
    bus.wb_we = 1'b0;
    expect_val("rst_blocks_wr", S_RA, 32'h0);
    cyc();
    R = 1'b1;
    expect_val("after_rst_r3", S_RA, 32'h0);

    // Writes resume after release
    bus.wb_we = 1'b1; bus.wb_addr = 4'd6; bus.wb_data = 32'h00000055;
    cyc();
    bus.wb_we = 1'b0;
    bus.rd_addr = 4'd6;
    expect_val("resume_r6", S_RD, 32'h00000055);

    cyc();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
